// File: rtl/pspin_pkt_match_ctrl.sv
// Rule-configuration controller for the PsPIN match engine: host writes fill a
// shadow rule bank that is copied to the active match_* outputs only at RX packet boundaries.
module pspin_pkt_match_ctrl #(
  parameter int UMATCH_WIDTH   = 32,
  parameter int UMATCH_ENTRIES = 16,
  parameter int UMATCH_MODES   = 2,
  parameter int ENTRY_W        = $clog2(UMATCH_ENTRIES),
  parameter int MODE_W         = $clog2(UMATCH_MODES)
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   cfg_wr_en,
  output logic                                   cfg_wr_ready,
  input  logic [2:0]                             cfg_wr_field,
  input  logic [ENTRY_W-1:0]                     cfg_wr_entry,
  input  logic [UMATCH_WIDTH-1:0]                cfg_wr_data,
  input  logic                                   cfg_commit,
  input  logic                                   cfg_commit_valid,
  output logic                                   cfg_busy,
  output logic                                   cfg_done,
  output logic [15:0]                            cfg_commit_cnt,
  input  logic                                   mon_tvalid,
  input  logic                                   mon_tready,
  input  logic                                   mon_tlast,
  output logic [MODE_W-1:0]                      match_mode,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_idx,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_mask,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_start,
  output logic [UMATCH_WIDTH*UMATCH_ENTRIES-1:0] match_end,
  output logic                                   match_valid
);

  typedef logic [UMATCH_ENTRIES-1:0][UMATCH_WIDTH-1:0] bank_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic hs;
  logic in_pkt_q, in_pkt_d;
  logic swap_ok;
  logic wr_acc;
  logic do_swap;
  logic swap_valid;
  logic pend_valid_q, pend_valid_d;

  bank_t             sh_idx_q, sh_idx_d;
  bank_t             sh_mask_q, sh_mask_d;
  bank_t             sh_start_q, sh_start_d;
  bank_t             sh_end_q, sh_end_d;
  logic [MODE_W-1:0] sh_mode_q, sh_mode_d;

  bank_t             act_idx_q, act_mask_q, act_start_q, act_end_q;
  logic [MODE_W-1:0] act_mode_q;
  logic              act_valid_q;
  logic              done_q;
  logic [15:0]       cnt_q;

  // Packet boundary tracking: a swap is safe whenever no packet is open after this edge.
  assign hs       = mon_tvalid & mon_tready;
  assign in_pkt_d = hs ? ~mon_tlast : in_pkt_q;
  assign swap_ok  = ~in_pkt_d;

  assign wr_acc = cfg_wr_en & (state_q == IDLE);

  // Shadow next-state is also the copy source, so a same-cycle write is part of the commit.
  always_comb begin
    sh_idx_d   = sh_idx_q;
    sh_mask_d  = sh_mask_q;
    sh_start_d = sh_start_q;
    sh_end_d   = sh_end_q;
    sh_mode_d  = sh_mode_q;
    if (wr_acc) begin
      case (cfg_wr_field)
        3'd0:    sh_idx_d[cfg_wr_entry]   = cfg_wr_data;
        3'd1:    sh_mask_d[cfg_wr_entry]  = cfg_wr_data;
        3'd2:    sh_start_d[cfg_wr_entry] = cfg_wr_data;
        3'd3:    sh_end_d[cfg_wr_entry]   = cfg_wr_data;
        3'd4:    sh_mode_d                = cfg_wr_data[MODE_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    do_swap      = 1'b0;
    swap_valid   = pend_valid_q;
    cfg_wr_ready = (state_q == IDLE);
    cfg_busy     = (state_q == PENDING);
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          if (swap_ok) begin
            do_swap    = 1'b1;
            swap_valid = cfg_commit_valid;
          end else begin
            state_d      = PENDING;
            pend_valid_d = cfg_commit_valid;
          end
        end
      end
      PENDING: begin
        if (swap_ok) begin
          do_swap = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      in_pkt_q     <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_pkt_q     <= in_pkt_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_idx_q   <= '0;
      sh_mask_q  <= '0;
      sh_start_q <= '0;
      sh_end_q   <= '0;
      sh_mode_q  <= '0;
    end else begin
      sh_idx_q   <= sh_idx_d;
      sh_mask_q  <= sh_mask_d;
      sh_start_q <= sh_start_d;
      sh_end_q   <= sh_end_d;
      sh_mode_q  <= sh_mode_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_idx_q   <= '0;
      act_mask_q  <= '0;
      act_start_q <= '0;
      act_end_q   <= '0;
      act_mode_q  <= '0;
      act_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= do_swap;
      if (do_swap) begin
        act_idx_q   <= sh_idx_d;
        act_mask_q  <= sh_mask_d;
        act_start_q <= sh_start_d;
        act_end_q   <= sh_end_d;
        act_mode_q  <= sh_mode_d;
        act_valid_q <= swap_valid;
        cnt_q       <= cnt_q + 16'd1;
      end
    end
  end

  assign match_idx      = act_idx_q;
  assign match_mask     = act_mask_q;
  assign match_start    = act_start_q;
  assign match_end      = act_end_q;
  assign match_mode     = act_mode_q;
  assign match_valid    = act_valid_q;
  assign cfg_done       = done_q;
  assign cfg_commit_cnt = cnt_q;

endmodule

// File: tb/tb_pspin_pkt_match_ctrl.sv
// Scoreboard bench for pspin_pkt_match_ctrl: a transaction-level model predicts each
// commit (rule snapshot, valid, count, completion cycle); a monitor checks every cycle.
module tb_pspin_pkt_match_ctrl;

  localparam int W     = 32;
  localparam int E     = 16;
  localparam int MODES = 2;
  localparam int EW    = 4;
  localparam int MW    = 1;
  localparam int FW    = W * E;

  typedef struct {
    logic [FW-1:0] idx;
    logic [FW-1:0] mask;
    logic [FW-1:0] st;
    logic [FW-1:0] en;
    logic [MW-1:0] mode;
    logic          valid;
    logic [15:0]   cnt;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_wr_ready;
  logic [2:0]    cfg_wr_field = '0;
  logic [EW-1:0] cfg_wr_entry = '0;
  logic [W-1:0]  cfg_wr_data = '0;
  logic          cfg_commit = 1'b0;
  logic          cfg_commit_valid = 1'b0;
  logic          cfg_busy;
  logic          cfg_done;
  logic [15:0]   cfg_commit_cnt;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic [MW-1:0] match_mode;
  logic [FW-1:0] match_idx, match_mask, match_start, match_end;
  logic          match_valid;

  pspin_pkt_match_ctrl #(
    .UMATCH_WIDTH  (W),
    .UMATCH_ENTRIES(E),
    .UMATCH_MODES  (MODES)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_ready    (cfg_wr_ready),
    .cfg_wr_field    (cfg_wr_field),
    .cfg_wr_entry    (cfg_wr_entry),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_commit      (cfg_commit),
    .cfg_commit_valid(cfg_commit_valid),
    .cfg_busy        (cfg_busy),
    .cfg_done        (cfg_done),
    .cfg_commit_cnt  (cfg_commit_cnt),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .match_mode      (match_mode),
    .match_idx       (match_idx),
    .match_mask      (match_mask),
    .match_start     (match_start),
    .match_end       (match_end),
    .match_valid     (match_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: rule tables, open-packet flag, outstanding commit.
  logic [E-1:0][W-1:0] m_idx, m_mask, m_start, m_end;
  logic [MW-1:0]       m_mode;
  logic                m_in_pkt, m_pending, m_pend_valid;
  logic [15:0]         m_cnt;
  logic                exp_busy = 1'b0;
  exp_t                sb[$];
  exp_t                last;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_idx = '0; m_mask = '0; m_start = '0; m_end = '0; m_mode = '0;
    m_in_pkt = 1'b0; m_pending = 1'b0; m_pend_valid = 1'b0; m_cnt = '0;
    exp_busy = 1'b0;
    sb.delete();
  endtask

  task automatic push_commit(input logic v);
    exp_t e;
    m_cnt   = m_cnt + 16'd1;
    e.idx   = m_idx;
    e.mask  = m_mask;
    e.st    = m_start;
    e.en    = m_end;
    e.mode  = m_mode;
    e.valid = v;
    e.cnt   = m_cnt;
    e.due   = cyc + 1;
    sb.push_back(e);
  endtask

  // One clock of intent: accepted write lands first, then the commit snapshots the tables.
  task automatic model_step();
    logic pkt_open_after;
    pkt_open_after = (mon_tvalid && mon_tready) ? !mon_tlast : m_in_pkt;
    if (cfg_wr_en && !m_pending) begin
      case (cfg_wr_field)
        3'd0:    m_idx[cfg_wr_entry]   = cfg_wr_data;
        3'd1:    m_mask[cfg_wr_entry]  = cfg_wr_data;
        3'd2:    m_start[cfg_wr_entry] = cfg_wr_data;
        3'd3:    m_end[cfg_wr_entry]   = cfg_wr_data;
        3'd4:    m_mode                = cfg_wr_data[MW-1:0];
        default: ;
      endcase
    end
    if (!m_pending) begin
      if (cfg_commit) begin
        if (!pkt_open_after) push_commit(cfg_commit_valid);
        else begin
          m_pending    = 1'b1;
          m_pend_valid = cfg_commit_valid;
        end
      end
    end else if (!pkt_open_after) begin
      push_commit(m_pend_valid);
      m_pending = 1'b0;
    end
    m_in_pkt = pkt_open_after;
  endtask

  task automatic cycle(input logic we, input logic [2:0] fld, input logic [EW-1:0] ent,
                       input logic [W-1:0] dat, input logic cm, input logic cv,
                       input logic tv, input logic tr, input logic tl);
    cfg_wr_en = we; cfg_wr_field = fld; cfg_wr_entry = ent; cfg_wr_data = dat;
    cfg_commit = cm; cfg_commit_valid = cv;
    mon_tvalid = tv; mon_tready = tr; mon_tlast = tl;
    model_step();
    @(posedge clk);
    #1;
    exp_busy = m_pending;
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pops an expectation on every cfg_done, otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rstn) begin
      last = '{idx: '0, mask: '0, st: '0, en: '0, mode: '0, valid: 1'b0, cnt: '0, due: 0};
    end else begin
      chk("busy", FW'(cfg_busy), FW'(exp_busy));
      chk("wr_ready", FW'(cfg_wr_ready), FW'(!exp_busy));
      if (cfg_done) begin
        if (sb.size() == 0) chk("done_unexpected", FW'(cfg_done), FW'(1'b0));
        else begin
          last = sb.pop_front();
          chk("done_cycle", FW'(cyc), FW'(last.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        chk("done_missing", FW'(cfg_done), FW'(1'b1));
        last = sb.pop_front();
      end
      chk("match_idx", match_idx, last.idx);
      chk("match_mask", match_mask, last.mask);
      chk("match_start", match_start, last.st);
      chk("match_end", match_end, last.en);
      chk("match_mode", FW'(match_mode), FW'(last.mode));
      chk("match_valid", FW'(match_valid), FW'(last.valid));
      chk("commit_cnt", FW'(cfg_commit_cnt), FW'(last.cnt));
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not reach the end (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("rst_idx", match_idx, '0);
    chk("rst_mask", match_mask, '0);
    chk("rst_valid", FW'(match_valid), FW'(1'b0));
    chk("rst_wr_ready", FW'(cfg_wr_ready), FW'(1'b1));
    chk("rst_cnt", FW'(cfg_commit_cnt), FW'(16'd0));
    @(posedge clk);
    #1;

    // Idle commit of entry 3.
    cycle(1'b1, 3'd0, 4'd3, 32'd12,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 4'd3, 32'hFFFF,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 4'd3, 32'h0800,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd3, 4'd3, 32'h0800,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 3'd4, 4'd9, 32'h1,       1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_done", FW'(cfg_done), FW'(1'b1));
    chk("idle_idx3", FW'(match_idx[3*W +: W]), FW'(32'd12));
    chk("idle_mask3", FW'(match_mask[3*W +: W]), FW'(32'hFFFF));
    chk("idle_start3", FW'(match_start[3*W +: W]), FW'(32'h0800));
    chk("idle_end3", FW'(match_end[3*W +: W]), FW'(32'h0800));
    chk("idle_mode", FW'(match_mode), FW'(1'b1));
    chk("idle_valid", FW'(match_valid), FW'(1'b1));
    chk("idle_cnt", FW'(cfg_commit_cnt), FW'(16'd1));
    idle();
    chk("idle_done_pulse", FW'(cfg_done), FW'(1'b0));

    // Commit during beat 2 of a 4-beat packet; a write during PENDING is refused.
    cycle(1'b1, 3'd0, 4'd5, 32'hA5,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("mid_busy", FW'(cfg_busy), FW'(1'b1));
    chk("mid_wr_ready", FW'(cfg_wr_ready), FW'(1'b0));
    chk("mid_idx5_old", FW'(match_idx[5*W +: W]), FW'(32'h0));
    cycle(1'b1, 3'd0, 4'd5, 32'h77,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mid_idx5_hold", FW'(match_idx[5*W +: W]), FW'(32'h0));
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("mid_swap_done", FW'(cfg_done), FW'(1'b1));
    chk("mid_idx5_new", FW'(match_idx[5*W +: W]), FW'(32'hA5));
    chk("mid_busy_clear", FW'(cfg_busy), FW'(1'b0));
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Back-pressure: tlast presented but not accepted for 10 cycles.
    cycle(1'b1, 3'd1, 4'd6, 32'h1234,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b0, 3'd0, 4'd0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("bp_busy", FW'(cfg_busy), FW'(1'b1));
    chk("bp_mask6_old", FW'(match_mask[6*W +: W]), FW'(32'h0));
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("bp_done", FW'(cfg_done), FW'(1'b1));
    chk("bp_mask6_new", FW'(match_mask[6*W +: W]), FW'(32'h1234));

    // Single-beat packet with write and commit in the same cycle.
    cycle(1'b1, 3'd2, 4'd7, 32'h55,      1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("sb_done", FW'(cfg_done), FW'(1'b1));
    chk("sb_start7", FW'(match_start[7*W +: W]), FW'(32'h55));
    chk("sb_busy", FW'(cfg_busy), FW'(1'b0));

    // Second commit while PENDING is absorbed.
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("dbl_cnt", FW'(cfg_commit_cnt), FW'(16'd5));
    chk("dbl_valid", FW'(match_valid), FW'(1'b1));

    // Disable via commit valid = 0.
    cycle(1'b1, 3'd3, 4'd0, 32'hBEEF,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_valid", FW'(match_valid), FW'(1'b0));
    chk("dis_end0", FW'(match_end[0 +: W]), FW'(32'hBEEF));

    // Randomized traffic, writes and commits.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 3) == 0, 3'($urandom), EW'($urandom), $urandom,
            ($urandom % 8) == 0, 1'($urandom), 1'($urandom), ($urandom % 4) != 0,
            ($urandom % 4) == 0);
    end
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) idle();

    // Reset while PENDING drops the commit and clears everything.
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 3'd0, 4'd0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("rp_busy", FW'(cfg_busy), FW'(1'b1));
    #2;
    rstn = 1'b0;
    cfg_commit = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    #1;
    model_reset();
    chk("rp_idx", match_idx, '0);
    chk("rp_mask", match_mask, '0);
    chk("rp_start", match_start, '0);
    chk("rp_end", match_end, '0);
    chk("rp_mode", FW'(match_mode), FW'(1'b0));
    chk("rp_valid", FW'(match_valid), FW'(1'b0));
    chk("rp_cnt", FW'(cfg_commit_cnt), FW'(16'd0));
    chk("rp_done", FW'(cfg_done), FW'(1'b0));
    chk("rp_busy_clear", FW'(cfg_busy), FW'(1'b0));
    chk("rp_wr_ready", FW'(cfg_wr_ready), FW'(1'b1));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle();

    // 65536 commits after reset: counter returns to zero.
    for (int i = 0; i < 65536; i++)
      cycle(1'b0, 3'd0, 4'd0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_cnt", FW'(cfg_commit_cnt), FW'(16'd0));
    repeat (3) idle();
    chk("sb_drained", FW'(sb.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
